// File: rtl/cnn_pkg.sv
// Shared types and helpers for the sequential CNN cell evaluator.
// Imported by the cell FSM, its nonlinearity and array-level wrappers.
package cnn_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_FINAL,
        S_OUT
    } state_t;

    localparam logic [1:0] MODE_PWL  = 2'b00;
    localparam logic [1:0] MODE_RELU = 2'b01;
    localparam logic [1:0] MODE_ID   = 2'b10;

    // Wide enough for 2*TAPS full-scale products plus the bias term.
    function automatic int acc_width(input int width, input int taps);
        return 2 * width + $clog2(2 * taps + 1);
    endfunction

endpackage

// File: rtl/cnn_cell_seq_if.sv
// Operand/result handshake bundle for cnn_cell_seq.
// master = producer/consumer side, slave = the cell.
interface cnn_cell_seq_if #(
    parameter int WIDTH = 9,
    parameter int TAPS  = 9
);
    logic                    in_valid;
    logic                    in_ready;
    logic [TAPS*WIDTH-1:0]   a_taps;
    logic [TAPS*WIDTH-1:0]   b_taps;
    logic [TAPS*WIDTH-1:0]   y_nbr;
    logic [TAPS*WIDTH-1:0]   u_nbr;
    logic [WIDTH-1:0]        bias;
    logic [1:0]              mode;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_x;
    logic [WIDTH-1:0]        out_y;
    logic                    sat_flag;

    modport master (
        output in_valid, a_taps, b_taps, y_nbr, u_nbr, bias, mode,
        output out_ready,
        input  in_ready, out_valid, out_x, out_y, sat_flag
    );

    modport slave (
        input  in_valid, a_taps, b_taps, y_nbr, u_nbr, bias, mode,
        input  out_ready,
        output in_ready, out_valid, out_x, out_y, sat_flag
    );

endinterface

// File: rtl/cnn_nonlin.sv
// Saturates a wide cell state to WIDTH bits and applies the
// selected output nonlinearity. Purely combinational.
module cnn_nonlin
    import cnn_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int FRAC  = 6,
    parameter int XW    = 23
) (
    input  logic signed [XW-1:0]    x_full,
    input  logic [1:0]              mode,
    output logic signed [WIDTH-1:0] x_sat,
    output logic signed [WIDTH-1:0] y,
    output logic                    sat
);

    localparam logic signed [XW-1:0] XMAX = XW'((1 << (WIDTH - 1)) - 1);
    localparam logic signed [XW-1:0] XMIN = ~XMAX;
    localparam logic signed [WIDTH-1:0] ONE  = WIDTH'(1 << FRAC);
    localparam logic signed [WIDTH-1:0] NONE = WIDTH'(-(1 << FRAC));

    always_comb begin
        sat   = 1'b0;
        x_sat = x_full[WIDTH-1:0];
        if (x_full > XMAX) begin
            sat   = 1'b1;
            x_sat = XMAX[WIDTH-1:0];
        end else if (x_full < XMIN) begin
            sat   = 1'b1;
            x_sat = XMIN[WIDTH-1:0];
        end
    end

    // Mode 11 is unassigned and falls back to the PWL clamp.
    always_comb begin
        y = x_sat;
        unique case (mode)
            MODE_RELU: begin
                if (x_sat < 0)
                    y = '0;
                else if (x_sat > ONE)
                    y = ONE;
            end
            MODE_ID: y = x_sat;
            default: begin
                if (x_sat > ONE)
                    y = ONE;
                else if (x_sat < NONE)
                    y = NONE;
            end
        endcase
    end

endmodule

// File: rtl/cnn_cell_seq.sv
// Sequential CNN cell: one A*Y + B*U tap pair per cycle through
// a shared MAC, then bias, floor shift, saturation and nonlinearity.
module cnn_cell_seq
    import cnn_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int FRAC  = 6,
    parameter int TAPS  = 9
) (
    input logic          clk,
    input logic          rst,
    cnn_cell_seq_if.slave bus
);

    localparam int ACCW = acc_width(WIDTH, TAPS);
    localparam int TW   = TAPS * WIDTH;
    localparam int IW   = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int PW   = 2 * WIDTH;

    state_t                 state;
    logic [TW-1:0]          a_r, b_r, y_r, u_r;
    logic signed [WIDTH-1:0] bias_r;
    logic [1:0]             mode_r;
    logic signed [ACCW-1:0] acc;
    logic [IW-1:0]          idx;
    logic                   ov_r, sf_r;
    logic [WIDTH-1:0]       ox_r, oy_r;

    logic signed [WIDTH-1:0] a_k, b_k, y_k, u_k;
    logic signed [PW-1:0]    pa, pb;
    logic signed [ACCW-1:0]  mac, bias_ext, acc_fin, x_full;
    logic signed [WIDTH-1:0] nl_x, nl_y;
    logic                    nl_sat;

    always_comb begin
        a_k = a_r[idx*WIDTH +: WIDTH];
        b_k = b_r[idx*WIDTH +: WIDTH];
        y_k = y_r[idx*WIDTH +: WIDTH];
        u_k = u_r[idx*WIDTH +: WIDTH];
        pa  = a_k * y_k;
        pb  = b_k * u_k;
        mac = {{(ACCW-PW){pa[PW-1]}}, pa}
            + {{(ACCW-PW){pb[PW-1]}}, pb};
        bias_ext = {{(ACCW-WIDTH){bias_r[WIDTH-1]}}, bias_r};
        acc_fin  = acc + (bias_ext <<< FRAC);
        x_full   = acc_fin >>> FRAC;
    end

    cnn_nonlin #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC),
        .XW    (ACCW)
    ) u_nonlin (
        .x_full (x_full),
        .mode   (mode_r),
        .x_sat  (nl_x),
        .y      (nl_y),
        .sat    (nl_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            a_r    <= '0;
            b_r    <= '0;
            y_r    <= '0;
            u_r    <= '0;
            bias_r <= '0;
            mode_r <= '0;
            acc    <= '0;
            idx    <= '0;
            ov_r   <= 1'b0;
            sf_r   <= 1'b0;
            ox_r   <= '0;
            oy_r   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        a_r    <= bus.a_taps;
                        b_r    <= bus.b_taps;
                        y_r    <= bus.y_nbr;
                        u_r    <= bus.u_nbr;
                        bias_r <= bus.bias;
                        mode_r <= bus.mode;
                        acc    <= '0;
                        idx    <= '0;
                        state  <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc <= acc + mac;
                    if (idx == IW'(TAPS - 1)) begin
                        idx   <= '0;
                        state <= S_FINAL;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_FINAL: begin
                    acc   <= acc_fin;
                    ox_r  <= nl_x;
                    oy_r  <= nl_y;
                    sf_r  <= nl_sat;
                    ov_r  <= 1'b1;
                    state <= S_OUT;
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        ov_r  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = ov_r;
    assign bus.out_x     = ox_r;
    assign bus.out_y     = oy_r;
    assign bus.sat_flag  = sf_r;

endmodule

// File: tb/tb_cnn_cell_seq.sv
// Directed bench for cnn_cell_seq with hand-computed results.
// Inputs change and outputs are sampled 1ns after rising edges.
`timescale 1ns/1ps
module tb_cnn_cell_seq;

    localparam int W = 9;
    localparam int T = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errs = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    cnn_cell_seq_if #(.WIDTH(W), .TAPS(T)) bus ();

    cnn_cell_seq #(
        .WIDTH (W),
        .FRAC  (6),
        .TAPS  (T)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ops();
        bus.a_taps = '0;
        bus.b_taps = '0;
        bus.y_nbr  = '0;
        bus.u_nbr  = '0;
        bus.bias   = '0;
        bus.mode   = 2'b00;
    endtask

    task automatic set_tap(input int sel, input int k, input int v);
        logic [W-1:0] t;
        t = W'(v);
        case (sel)
            0: bus.a_taps[k*W +: W] = t;
            1: bus.b_taps[k*W +: W] = t;
            2: bus.y_nbr[k*W +: W]  = t;
            default: bus.u_nbr[k*W +: W] = t;
        endcase
    endtask

    // Accept, wait for the result, then leave it pending in OUT.
    task automatic launch(input string tag, output int lat);
        int n;
        n = 0;
        while (!bus.in_ready && n < 40) begin
            step();
            n++;
        end
        check({tag, "_rdy"}, int'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic take();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic run(input string tag, input int ex_x, input int ex_y,
                       input int ex_sat);
        int lat;
        launch(tag, lat);
        check({tag, "_lat"}, lat, 10);
        check({tag, "_x"}, int'($signed(bus.out_x)), ex_x);
        check({tag, "_y"}, int'($signed(bus.out_y)), ex_y);
        check({tag, "_sat"}, int'(bus.sat_flag), ex_sat);
        take();
        check({tag, "_done"}, int'(bus.out_valid), 0);
    endtask

    initial begin
        int lat;
        logic [W-1:0] hold_x;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        clear_ops();
        step();
        step();
        rst = 1'b0;
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_x", int'(bus.out_x), 0);
        check("rst_out_y", int'(bus.out_y), 0);
        check("rst_sat", int'(bus.sat_flag), 0);

        clear_ops();
        bus.bias = 9'd32;
        run("bias32", 32, 32, 0);

        clear_ops();
        for (int k = 0; k < T; k++) begin
            set_tap(1, k, 64);
            set_tap(3, k, 64);
        end
        set_tap(0, 4, 64);
        set_tap(2, 4, 64);
        run("pos_pwl", 255, 64, 1);
        bus.mode = 2'b10;
        run("pos_id", 255, 255, 1);

        clear_ops();
        for (int k = 0; k < T; k++) begin
            set_tap(1, k, -64);
            set_tap(3, k, 64);
        end
        run("neg_pwl", -256, -64, 1);
        bus.mode = 2'b01;
        run("neg_relu", -256, 0, 1);
        bus.mode = 2'b11;
        run("neg_m11", -256, -64, 1);

        clear_ops();
        set_tap(0, 0, 1);
        set_tap(2, 0, 1);
        run("floor_pos", 0, 0, 0);
        set_tap(0, 0, -1);
        run("floor_neg", -1, -1, 0);

        clear_ops();
        bus.bias = W'(255);
        run("edge_max", 255, 64, 0);
        bus.bias = W'(-10);
        bus.mode = 2'b01;
        run("relu_neg", -10, 0, 0);

        // Backpressure: new operands offered while the result is held.
        clear_ops();
        bus.bias = 9'd20;
        bus.mode = 2'b10;
        launch("bp", lat);
        check("bp_lat", lat, 10);
        hold_x = bus.out_x;
        bus.bias = 9'd99;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            check("bp_valid", int'(bus.out_valid), 1);
            check("bp_x", int'(bus.out_x), int'(hold_x));
            check("bp_in_ready", int'(bus.in_ready), 0);
        end
        check("bp_x_val", int'($signed(bus.out_x)), 20);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b0;
        check("bp_done", int'(bus.out_valid), 0);
        check("bp_in_ready2", int'(bus.in_ready), 1);
        step();
        check("bp_no_accept", int'(bus.in_ready), 1);

        // Reset in the middle of the MAC phase drops the transaction.
        clear_ops();
        bus.bias = 9'd77;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        check("mid_busy", int'(bus.in_ready), 0);
        for (int c = 0; c < 3; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_valid", int'(bus.out_valid), 0);
        check("mid_rst_ready", int'(bus.in_ready), 1);
        for (int c = 0; c < 12; c++) step();
        check("mid_rst_quiet", int'(bus.out_valid), 0);
        bus.bias = 9'd32;
        run("post_rst", 32, 32, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
